frac_fir_mac: RTL and testbench

- Parametrised successor to the fixed 3-tap fractional-order (Grünwald-Letnikov) FIR operator.
- Generalises tap count, data/coefficient width and Q-format.
- Adds runtime-loadable coefficients, a valid/ready input handshake, and a single time-multiplexed multiplier-accumulator.
- Adds convergent-free round-half-up requantisation with saturation.
- Sits between the sample source and the fractional-order controller datapath; one output sample per accepted input sample.

---
 rtl/frac_fir_mac.sv | 168 ++++++++++++++++
 tb/tb_frac_fir_mac.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_fir_mac.sv
// Fractional-order FIR operator: loadable taps, one shared multiplier-accumulator
// stepping one tap per cycle, then round-half-up and saturate to the output width.
module frac_fir_mac #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned COEF_W    = 32,
  parameter int unsigned FRAC_BITS = 24,
  parameter int unsigned TAPS      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     hist_clr,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int unsigned ADDR_W = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);

  localparam logic signed [ACC_W-1:0]  RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX  = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0]  SAT_MIN  = ~SAT_MAX;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         tap_q, tap_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  x_q    [TAPS];
  logic signed [DATA_W-1:0]  x_d    [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [COEF_W-1:0]  coef_d [TAPS];
  logic signed [DATA_W-1:0]  res_q, res_d;
  logic                      sat_q, sat_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;

  logic                      accept;
  logic signed [DATA_W-1:0]  x_sel;
  logic signed [COEF_W-1:0]  c_sel;
  logic signed [PROD_W-1:0]  mul_prod;
  logic signed [ACC_W-1:0]   rnd_sum;
  logic signed [ACC_W-1:0]   rnd_shr;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Shared datapath: selected tap product and rounded/shifted accumulator
  always_comb begin
    x_sel    = x_q[tap_q];
    c_sel    = coef_q[tap_q];
    mul_prod = PROD_W'(x_sel) * PROD_W'(c_sel);
    rnd_sum  = acc_q + RND_HALF;
    rnd_shr  = rnd_sum >>> FRAC_BITS;
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    x_d         = x_q;
    coef_d      = coef_q;
    res_d       = res_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      IDLE: begin
        // Out-of-range addresses match no entry and are dropped
        for (int unsigned k = 0; k < TAPS; k++) begin
          if (coef_we && (coef_addr == ADDR_W'(k))) coef_d[k] = coef_wdata;
        end
        if (hist_clr) begin
          for (int unsigned k = 0; k < TAPS; k++) x_d[k] = '0;
        end
        if (accept) begin
          for (int unsigned k = 1; k < TAPS; k++) begin
            x_d[k] = hist_clr ? '0 : x_q[k-1];
          end
          x_d[0]  = in_data;
          tap_d   = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(mul_prod);
        if (tap_q == ADDR_W'(TAPS - 1)) begin
          state_d = ROUND;
        end else begin
          tap_d = tap_q + ADDR_W'(1);
        end
      end
      ROUND: begin
        if (rnd_shr > SAT_MAX) begin
          res_d = SAT_MAX[DATA_W-1:0];
          sat_d = 1'b1;
        end else if (rnd_shr < SAT_MIN) begin
          res_d = SAT_MIN[DATA_W-1:0];
          sat_d = 1'b1;
        end else begin
          res_d = rnd_shr[DATA_W-1:0];
          sat_d = 1'b0;
        end
        state_d = OUT;
      end
      OUT: begin
        out_valid_d = 1'b1;
        out_data_d  = res_q;
        out_sat_d   = sat_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers; reset restores unity passthrough coefficients
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= (k == 0) ? COEF_ONE : '0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
    end
  end

endmodule

// File: tb/tb_frac_fir_mac.sv
// Directed self-checking bench for frac_fir_mac (5 taps so an out-of-range address exists).
module tb_frac_fir_mac;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned COEF_W    = 32;
  localparam int unsigned FRAC_BITS = 24;
  localparam int unsigned TAPS      = 5;
  localparam int unsigned AW        = $clog2(TAPS);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              hist_clr;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [31:0] ov_q[$];

  frac_fir_mac #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .FRAC_BITS(FRAC_BITS),
    .TAPS     (TAPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .hist_clr  (hist_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (out_valid === 1'b1) ov_q.push_back(out_data);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
               tag, got, $signed(got), exp, $signed(exp));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [31:0] v);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    @(negedge clk);
    coef_we    = 1'b0;
  endtask

  // Present one sample; returns at the negedge following the accepting edge
  task automatic accept(input logic [31:0] d);
    int n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    hist_clr = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp, input logic exp_sat);
    int n = 0;
    while (!out_valid && n < int'(TAPS) + 16) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
    check({tag, "_lat"}, 32'(cyc - acc_cyc), TAPS + 2);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    check({tag, "_hold"}, out_data, exp);
  endtask

  initial begin
    logic [31:0] hs_exp [3];
    int          nacc;
    int          last_acc;
    int          n0;
    logic        rdy;

    hs_exp     = '{32'd10, 32'd20, 32'd30};
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    hist_clr   = 1'b0;
    @(negedge clk);
    do_reset();

    // Passthrough after reset
    accept(32'd1234);
    expect_out("pass0", 32'd1234, 1'b0);
    accept(32'(-77));
    expect_out("pass1", 32'(-77), 1'b0);

    // Writes while busy (in range and out of range) are dropped
    accept(32'd42);
    coef_we    = 1'b1;
    coef_addr  = '0;
    coef_wdata = '0;
    @(negedge clk);
    check("wp_busy", 32'(busy), 32'd1);
    coef_addr  = AW'(TAPS);
    coef_wdata = 32'h0100_0000;
    @(negedge clk);
    coef_we    = 1'b0;
    expect_out("wp_during", 32'd42, 1'b0);
    accept(32'd99);
    expect_out("wp_next", 32'd99, 1'b0);
    // Write in IDLE alongside an accept applies to that sample
    coef_we    = 1'b1;
    coef_addr  = '0;
    coef_wdata = '0;
    accept(32'd7);
    expect_out("wp_same", 32'd0, 1'b0);

    // Handshake with in_valid held high for three samples
    do_reset();
    ov_q.delete();
    in_valid = 1'b1;
    in_data  = 32'd10;
    nacc     = 0;
    last_acc = 0;
    for (int c = 0; c < 200 && nacc < 3; c++) begin
      check("hs_ready", 32'(in_ready), 32'(!busy));
      rdy = in_ready;
      @(negedge clk);
      if (rdy) begin
        nacc++;
        if (nacc > 1) check("hs_spacing", 32'(cyc - last_acc), TAPS + 3);
        last_acc = cyc;
        in_data  = (nacc == 1) ? 32'd20 : 32'd30;
      end
    end
    in_valid = 1'b0;
    check("hs_accepts", 32'(nacc), 32'd3);
    repeat (TAPS + 6) @(negedge clk);
    check("hs_count", 32'(ov_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < ov_q.size()) check("hs_data", ov_q[i], hs_exp[i]);
    end

    // Saturation with gain 2.0
    do_reset();
    write_coef(AW'(0), 32'h0200_0000);
    accept(32'h7FFF_FFFF);
    expect_out("sat_pos", 32'h7FFF_FFFF, 1'b1);
    accept(32'h8000_0000);
    expect_out("sat_neg", 32'h8000_0000, 1'b1);
    accept(32'd5);
    expect_out("sat_none", 32'd10, 1'b0);

    // Half-order Grunwald-Letnikov impulse response
    do_reset();
    write_coef(AW'(0), 32'd16777216);
    write_coef(AW'(1), 32'(-8388608));
    write_coef(AW'(2), 32'(-2097152));
    write_coef(AW'(3), 32'(-1048576));
    accept(32'd1000);
    expect_out("gl0", 32'd1000, 1'b0);
    accept(32'd0);
    expect_out("gl1", 32'(-500), 1'b0);
    accept(32'd0);
    expect_out("gl2", 32'(-125), 1'b0);
    accept(32'd0);
    expect_out("gl3", 32'(-62), 1'b0);
    accept(32'd0);
    expect_out("gl4", 32'd0, 1'b0);

    // hist_clr in IDLE, together with an accept, and while busy
    accept(32'd1000);
    expect_out("hc_pre", 32'd1000, 1'b0);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    accept(32'd0);
    expect_out("hc_idle", 32'd0, 1'b0);
    accept(32'd1000);
    expect_out("hc_pre2", 32'd1000, 1'b0);
    hist_clr = 1'b1;
    accept(32'd8);
    expect_out("hc_accept", 32'd8, 1'b0);
    accept(32'd0);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    expect_out("hc_busy0", 32'(-4), 1'b0);
    accept(32'd0);
    expect_out("hc_busy1", 32'(-1), 1'b0);

    // Reset two cycles into MAC aborts the sample and restores state
    accept(32'd777);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n0  = ov_q.size();
    repeat (TAPS + 8) @(negedge clk);
    check("abort_no_out", 32'(ov_q.size()), 32'(n0));
    check("abort_idle", 32'(busy), 32'd0);
    write_coef(AW'(1), 32'h0100_0000);
    accept(32'd400);
    expect_out("abort_line", 32'd400, 1'b0);
    accept(32'd0);
    expect_out("abort_c1", 32'd400, 1'b0);
    accept(32'd0);
    expect_out("abort_c2", 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
